// File: rtl/exp3_input_sequencer.sv
// exp3_input_sequencer
//   Stimulus sequencer for the Experiment-3 4-in/4-out logic function.
//   Sweeps {a,b,c,d} from FIRST_CODE to LAST_CODE, holding each code for
//   DWELL_CYCLES unpaused cycles. After SETTLE_CYCLES it captures {f3,f2,f1,f0}
//   once per code and reports {code,result} with a one-cycle valid strobe.
//
// Ports
//   clk            in   rising-edge system clock
//   rst            in   asynchronous active-high reset
//   start          in   begin a sweep (honoured in IDLE or DONE only)
//   pause          in   freezes the dwell counter in SETTLE/HOLD
//   a,b,c,d        out  stimulus code, a is the MSB
//   f3,f2,f1,f0    in   response of the function under test, f3 is the MSB
//   sample_valid   out  one-cycle pulse, sample_code/sample_result valid
//   sample_code    out  code that was applied when the response was captured
//   sample_result  out  captured {f3,f2,f1,f0}
//   busy           out  high in SETTLE, SAMPLE and HOLD
//   done           out  high in DONE until start or rst
module exp3_input_sequencer #(
  parameter int DWELL_CYCLES  = 50,
  parameter int SETTLE_CYCLES = 25,
  parameter int FIRST_CODE    = 1,
  parameter int LAST_CODE     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       f3,
  input  logic       f2,
  input  logic       f1,
  input  logic       f0,
  output logic       sample_valid,
  output logic [3:0] sample_code,
  output logic [3:0] sample_result,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);

  // The sample cycle itself is one of the dwell cycles, so HOLD is
  // DWELL - SETTLE - 1 cycles long and its terminal count is one less.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(DWELL_CYCLES - SETTLE_CYCLES - 2);
  localparam logic [3:0]       FIRST       = 4'(FIRST_CODE);
  localparam logic [3:0]       LAST        = 4'(LAST_CODE);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("exp3_input_sequencer: SETTLE_CYCLES must be >= 1");
  end
  if (DWELL_CYCLES < SETTLE_CYCLES + 2) begin : g_bad_dwell
    $error("exp3_input_sequencer: DWELL_CYCLES must be >= SETTLE_CYCLES+2");
  end
  if (FIRST_CODE < 0 || LAST_CODE > 15 || FIRST_CODE > LAST_CODE) begin : g_bad_codes
    $error("exp3_input_sequencer: need 0 <= FIRST_CODE <= LAST_CODE <= 15");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    HOLD,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       code;
  logic [3:0]       code_next;
  logic             capture;

  // Next-state logic. The code register doubles as the stimulus output, so it
  // is zero only in IDLE (reached solely through reset) and keeps LAST_CODE
  // in DONE. The SAMPLE cycle is unconditional so pause cannot stretch it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    code_next  = code;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SETTLE;
          code_next  = FIRST;
          cnt_next   = '0;
        end
      end
      SETTLE: begin
        if (!pause) begin
          cnt_next = cnt + CNT_W'(1);
          if (cnt == SETTLE_LAST) begin
            state_next = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        capture    = 1'b1;
        state_next = HOLD;
        cnt_next   = '0;
      end
      HOLD: begin
        if (!pause) begin
          if (cnt == HOLD_LAST) begin
            if (code == LAST) begin
              state_next = DONE;
            end else begin
              state_next = SETTLE;
              code_next  = code + 4'd1;
              cnt_next   = '0;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (start) begin
          state_next = SETTLE;
          code_next  = FIRST;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        code_next  = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and capture registers. The valid strobe is the registered
  // SAMPLE indication, so it appears in the cycle after the capture edge and
  // a reset during the sweep can never leave a half-issued pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      code          <= '0;
      sample_valid  <= 1'b0;
      sample_code   <= '0;
      sample_result <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      code         <= code_next;
      sample_valid <= capture;
      if (capture) begin
        sample_code   <= code;
        sample_result <= {f3, f2, f1, f0};
      end
    end
  end

  assign {a, b, c, d} = code;
  assign busy         = (state == SETTLE) || (state == SAMPLE) || (state == HOLD);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_exp3_input_sequencer.sv
// tb_exp3_input_sequencer
//   Bench for exp3_input_sequencer. Three instances share clk/rst/start/pause:
//     0: defaults; f = ~{abcd}, or a 20-cycle-delayed {abcd} when f_mode=1
//     1: SETTLE_CYCLES=10, f = 20-cycle-delayed {abcd} (captures stale data)
//     2: FIRST_CODE=LAST_CODE=9, f = ~{abcd}
//   A dwell-position model predicts every output of every instance each cycle,
//   and directed sweeps pin pulse timing, codes and results with literals.
module tb_exp3_input_sequencer;

  localparam int D = 50;
  localparam int NI = 3;
  localparam int P_S[NI] = '{25, 10, 25};
  localparam int P_F[NI] = '{1, 1, 9};
  localparam int P_L[NI] = '{15, 15, 9};

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic pause;
  logic f_mode;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [3:0] ab[NI];
  logic [3:0] fin[NI];
  logic       sv[NI];
  logic [3:0] sc[NI];
  logic [3:0] sr[NI];
  logic       by[NI];
  logic       dn[NI];
  logic [3:0] dl[2][20];

  always #5 clk = ~clk;

  // Free-running cycle counter used to timestamp pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Delay lines emulating a slow function under test for instances 0 and 1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++)
        for (int j = 0; j < 20; j++) dl[k][j] <= 4'd0;
    end else begin
      dl[0][0] <= ab[0];
      dl[1][0] <= ab[1];
      for (int k = 0; k < 2; k++)
        for (int j = 1; j < 20; j++) dl[k][j] <= dl[k][j-1];
    end
  end

  assign fin[0] = f_mode ? dl[0][19] : ~ab[0];
  assign fin[1] = dl[1][19];
  assign fin[2] = ~ab[2];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    exp3_input_sequencer #(
      .DWELL_CYCLES (D),
      .SETTLE_CYCLES(g == 1 ? 10 : 25),
      .FIRST_CODE   (g == 2 ? 9 : 1),
      .LAST_CODE    (g == 2 ? 9 : 15)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .pause        (pause),
      .a            (ab[g][3]),
      .b            (ab[g][2]),
      .c            (ab[g][1]),
      .d            (ab[g][0]),
      .f3           (fin[g][3]),
      .f2           (fin[g][2]),
      .f1           (fin[g][1]),
      .f0           (fin[g][0]),
      .sample_valid (sv[g]),
      .sample_code  (sc[g]),
      .sample_result(sr[g]),
      .busy         (by[g]),
      .done         (dn[g])
    );
  end

  // Model: each sweep is a sequence of D-cycle dwells; m_pos is how many
  // unpaused cycles the current code has been applied. Cycle P_S is the
  // capture cycle and is never paused.
  int         m_pos[NI];
  logic [3:0] m_code[NI];
  logic [3:0] m_scode[NI];
  logic [3:0] m_sres[NI];
  logic [3:0] m_hist[NI][20];
  logic       m_run[NI];
  logic       m_done[NI];
  logic       m_valid[NI];

  initial forever begin
    @(posedge clk or posedge rst);
    for (int i = 0; i < NI; i++) begin
      logic [3:0] old;
      logic [3:0] fval;
      if (rst) begin
        m_pos[i] = 0; m_code[i] = 4'd0; m_scode[i] = 4'd0; m_sres[i] = 4'd0;
        m_run[i] = 1'b0; m_done[i] = 1'b0; m_valid[i] = 1'b0;
        for (int j = 0; j < 20; j++) m_hist[i][j] = 4'd0;
      end else begin
        old  = m_code[i];
        fval = (i == 2 || (i == 0 && !f_mode)) ? ~old : m_hist[i][19];
        m_valid[i] = 1'b0;
        if (m_run[i]) begin
          if (m_pos[i] == P_S[i]) begin
            m_scode[i] = old;
            m_sres[i]  = fval;
            m_valid[i] = 1'b1;
            m_pos[i]++;
          end else if (!pause) begin
            if (m_pos[i] == D - 1) begin
              if (int'(old) == P_L[i]) begin
                m_run[i]  = 1'b0;
                m_done[i] = 1'b1;
              end else begin
                m_code[i] = old + 4'd1;
                m_pos[i]  = 0;
              end
            end else begin
              m_pos[i]++;
            end
          end
        end else if (start) begin
          m_run[i]  = 1'b1;
          m_done[i] = 1'b0;
          m_code[i] = 4'(P_F[i]);
          m_pos[i]  = 0;
        end
        for (int j = 19; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
        m_hist[i][0] = old;
      end
    end
  end

  // Pulse recorder for the directed timing/value checks.
  int         np0 = 0;
  int         n1 = 0;
  int         n2 = 0;
  int         p_cyc[128];
  logic [3:0] p_code[128];
  logic [3:0] p_res[128];
  logic [3:0] p1_res[128];
  logic [3:0] p2_code;
  logic [3:0] p2_res;

  initial forever begin
    @(negedge clk);
    if (sv[0] && np0 < 128) begin
      p_cyc[np0]  = cyc;
      p_code[np0] = sc[0];
      p_res[np0]  = sr[0];
      np0++;
    end
    if (sv[1] && n1 < 128) begin
      p1_res[n1] = sr[1];
      n1++;
    end
    if (sv[2]) begin
      p2_code = sc[2];
      p2_res  = sr[2];
      n2++;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic compareAll();
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("inst%0d abcd c%0d", i, cyc), ab[i], m_code[i]);
      checkOutput($sformatf("inst%0d valid c%0d", i, cyc), sv[i], m_valid[i]);
      checkOutput($sformatf("inst%0d busy c%0d", i, cyc), by[i], m_run[i]);
      checkOutput($sformatf("inst%0d done c%0d", i, cyc), dn[i], m_done[i]);
      checkOutput($sformatf("inst%0d scode c%0d", i, cyc), sc[i], m_scode[i]);
      checkOutput($sformatf("inst%0d sres c%0d", i, cyc), sr[i], m_sres[i]);
    end
  endtask

  // Called just after a negedge; start (optionally with pause) is high for
  // exactly one rising edge, whose cycle number is returned.
  task automatic applyStimulus(input logic with_pause, output int e0);
    start = 1'b1;
    pause = with_pause;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic waitDone(input int max, output int t);
    t = -1;
    for (int k = 0; k < max; k++) begin
      if (dn[0]) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) checkOutput("wait for done timed out", 0, 1);
  endtask

  task automatic waitCode(input logic [3:0] code);
    int ok = 0;
    for (int k = 0; k < 2000; k++) begin
      if (ab[0] == code) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok == 0) checkOutput($sformatf("wait for code %0d timed out", code), 0, 1);
  endtask

  int e0;
  int junk;
  int tdone;
  int b0;
  int b1;
  int b2;

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; f_mode = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compareAll();
      end
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset abcd", ab[0], 0);
    checkOutput("reset busy", by[0], 0);
    checkOutput("reset done", dn[0], 0);
    checkOutput("reset valid", sv[0], 0);
    repeat (2) @(negedge clk);

    // Full sweep with start and pause together in IDLE, plus a start mid-sweep.
    b0 = np0; b1 = n1; b2 = n2;
    applyStimulus(1'b1, e0);
    repeat (208) @(negedge clk);
    applyStimulus(1'b0, junk);
    waitDone(800, tdone);
    checkOutput("sweep done time", tdone - e0, 750);
    checkOutput("sweep pulse count", np0 - b0, 15);
    for (int k = 0; k < 15; k++) begin
      if (b0 + k < 128) begin
        checkOutput($sformatf("sweep code %0d", k), p_code[b0+k], k + 1);
        checkOutput($sformatf("sweep result %0d", k), p_res[b0+k], (~(k + 1)) & 15);
        if (k == 0) checkOutput("first pulse latency", p_cyc[b0] - e0, 26);
        else checkOutput($sformatf("pulse gap %0d", k), p_cyc[b0+k] - p_cyc[b0+k-1], 50);
      end
    end
    checkOutput("sweep end abcd", ab[0], 15);
    checkOutput("stale settle first", p1_res[b1], 0);
    checkOutput("stale settle second", p1_res[b1+1], 1);
    checkOutput("single pulses", n2 - b2, 2);
    checkOutput("single code", p2_code, 9);
    checkOutput("single result", p2_res, 6);
    checkOutput("single done", dn[2], 1);
    checkOutput("single abcd", ab[2], 9);

    // Restart from DONE with a slow function under test.
    f_mode = 1'b1;
    b0 = np0;
    applyStimulus(1'b0, e0);
    checkOutput("restart abcd", ab[0], 1);
    checkOutput("restart done", dn[0], 0);
    waitDone(800, tdone);
    checkOutput("delayed pulse count", np0 - b0, 15);
    checkOutput("delayed first result", p_res[b0], 1);
    checkOutput("delayed last result", p_res[b0+14], 15);
    f_mode = 1'b0;
    @(negedge clk);

    // Pause 7 cycles in SETTLE of code 5, and one cycle over SAMPLE of code 7.
    b0 = np0;
    applyStimulus(1'b0, e0);
    waitCode(4'd5);
    repeat (3) @(negedge clk);
    pause = 1'b1;
    repeat (7) @(negedge clk);
    pause = 1'b0;
    waitCode(4'd7);
    repeat (25) @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    waitDone(900, tdone);
    checkOutput("paused done time", tdone - e0, 757);
    checkOutput("paused pulse count", np0 - b0, 15);
    checkOutput("code5 pulse time", p_cyc[b0+4] - e0, 233);
    checkOutput("code4-5 gap", p_cyc[b0+4] - p_cyc[b0+3], 57);
    checkOutput("code7 pulse time", p_cyc[b0+6] - e0, 333);
    checkOutput("code7-8 gap", p_cyc[b0+7] - p_cyc[b0+6], 50);

    // Asynchronous reset in HOLD of code 3.
    applyStimulus(1'b0, e0);
    waitCode(4'd3);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst abcd", ab[0], 0);
    checkOutput("async rst busy", by[0], 0);
    checkOutput("async rst valid", sv[0], 0);
    checkOutput("async rst scode", sc[0], 0);
    checkOutput("async rst sres", sr[0], 0);
    @(negedge clk);
    rst = 1'b0;
    b0 = np0;
    repeat (40) @(negedge clk);
    checkOutput("post rst pulses", np0 - b0, 0);
    checkOutput("post rst busy", by[0], 0);
    checkOutput("post rst abcd", ab[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
